// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between the core (m0) and the
// debug/program-loader port (m1). Each winning request is latched into one
// outstanding slave transaction; the slave may take any number of cycles to
// acknowledge, bounded by TIMEOUT, after which the access is aborted with err.
//
// Optional build macro: MEM_ARB_LOCK_EN
//   When defined, adds input m1_lock. While m1 was the last requester served
//   and m1_lock is high, m1 keeps the port even if the core is requesting,
//   so a debugger can perform an uninterrupted multi-word sequence.
//
// Handshake: a master raises req with its fields and holds req until it sees
// its one-cycle done pulse; it must drop req the cycle after done, otherwise
// the still-high req is taken as a new request. On the slave side s_req is
// raised with stable s_* fields and stays high until s_ack is seen (s_rdata
// is valid in the same cycle as s_ack) or the timeout fires.
//
// fsm_state exposes the arbiter state (0=IDLE, 1=ACCESS, 2=RESP) for
// observation.

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rstn,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_type,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_type,
`ifdef MEM_ARB_LOCK_EN
   input  logic              m1_lock,
`endif
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,

   output logic              s_req,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [2:0]        s_type,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ack,

   output logic              hold,
   output logic              err,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Timeout compare value; TIMEOUT is limited to 1..255 so 8 bits suffice.
   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state_q;
   state_t      state_d;

   // Requester encoding: 0 = m0 (core), 1 = m1 (debug).
   logic        grant_q;       // requester owning the current transaction
   logic        last_grant_q;  // requester served by the previous transaction
   logic        grant_d;       // arbitration result for a start in IDLE
   logic [7:0]  cnt_q;         // ACCESS cycles already spent without s_ack
   logic [7:0]  cnt_inc;
   logic        err_q;         // current transaction was aborted by timeout

   logic        start;         // IDLE with a request: latch winner
   logic        ack_hit;       // slave acknowledged in ACCESS
   logic        tmo_hit;       // timeout reached in ACCESS without s_ack

   assign cnt_inc = cnt_q + 8'd1;

   // Arbitration: single requester wins outright, simultaneous requests
   // alternate against the last requester served.
   always_comb begin
      grant_d = 1'b0;
      if (m0_req && m1_req) begin
         grant_d = ~last_grant_q;
      end else if (m1_req) begin
         grant_d = 1'b1;
      end
`ifdef MEM_ARB_LOCK_EN
      // A locked debug sequence keeps the port across core requests.
      if (last_grant_q && m1_lock && m1_req) begin
         grant_d = 1'b1;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and transaction events.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      ack_hit = 1'b0;
      tmo_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               start   = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // An acknowledge in the final allowed cycle still wins.
            if (s_ack) begin
               ack_hit = 1'b1;
               state_d = RESP;
            end else if (cnt_inc == TMO) begin
               tmo_hit = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slave-side registers: latched copies of the winner's fields.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_req   <= 1'b0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_type  <= 3'b000;
         grant_q <= 1'b0;
      end else begin
         if (start) begin
            grant_q <= grant_d;
            s_req   <= 1'b1;
            s_we    <= grant_d ? m1_we    : m0_we;
            s_addr  <= grant_d ? m1_addr  : m0_addr;
            s_wdata <= grant_d ? m1_wdata : m0_wdata;
            s_type  <= grant_d ? m1_type  : m0_type;
         end else if (ack_hit || tmo_hit) begin
            s_req   <= 1'b0;
         end
      end
   end

   // Timeout counter, abort flag and round-robin history.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q        <= 8'd0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         if (start) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
         end else if (state_q == ACCESS) begin
            if (tmo_hit) begin
               err_q <= 1'b1;
            end else if (!ack_hit) begin
               cnt_q <= cnt_inc;
            end
         end else if (state_q == RESP) begin
            cnt_q        <= 8'd0;
            last_grant_q <= grant_q;
         end
      end
   end

   // Read data returned to the owning master: slave data on an acknowledged
   // read, all ones on an aborted access, untouched on an acknowledged write.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         if (ack_hit && !s_we) begin
            if (grant_q) begin
               m1_rdata <= s_rdata;
            end else begin
               m0_rdata <= s_rdata;
            end
         end else if (tmo_hit) begin
            if (grant_q) begin
               m1_rdata <= '1;
            end else begin
               m0_rdata <= '1;
            end
         end
      end
   end

   // Completion pulses come straight from the one-cycle RESP state.
   assign m0_done   = (state_q == RESP) && !grant_q;
   assign m1_done   = (state_q == RESP) &&  grant_q;
   assign err       = (state_q == RESP) &&  err_q;

   // The core stalls for the whole time its request is outstanding,
   // including while the debug port owns the memory.
   assign hold      = m0_req && !m0_done;

   assign fsm_state = state_q;

endmodule
